// File: rtl/sseg_scan_arbiter.sv
// sseg_scan_arbiter: scans a 4-digit common-anode 7-segment display and
// arbitrates ownership between the primary BCD source and an alternate
// raw-segment requester. Ownership changes only on frame boundaries, so a
// frame is never split between the two sources.
//
// Optional build macro SSEG_LEADING_ZERO_BLANK_EN: when defined, leading
// zero digits 3..1 of the primary value are blanked. Digit 0 is always shown.
module sseg_scan_arbiter #(
  parameter int unsigned HOLD_FRAMES    = 250,
  parameter int unsigned MIN_PRI_FRAMES = 125,
  parameter int unsigned BLINK_FRAMES   = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_tick,
  input  logic [15:0] pri_bcd,
  input  logic [3:0]  pri_dp,
  input  logic        blink,
  input  logic        alt_req,
  input  logic [31:0] alt_seg,
  output logic        alt_gnt,
  output logic [3:0]  an,
  output logic [7:0]  sseg
);

  localparam int unsigned HOLD_W  = (HOLD_FRAMES    > 1) ? $clog2(HOLD_FRAMES)    : 1;
  localparam int unsigned COOL_W  = (MIN_PRI_FRAMES > 1) ? $clog2(MIN_PRI_FRAMES) : 1;
  localparam int unsigned BLINK_W = (BLINK_FRAMES   > 1) ? $clog2(BLINK_FRAMES)   : 1;
  localparam int unsigned DIG_W   = 2;

  typedef enum logic [1:0] {
    ST_PRI  = 2'd0,
    ST_ALT  = 2'd1,
    ST_COOL = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DIG_W-1:0]   digit_q, digit_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [COOL_W-1:0]  cool_cnt_q, cool_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic               alt_gnt_q, alt_gnt_d;
  logic [3:0]         an_q, an_d;
  logic [7:0]         sseg_q, sseg_d;

  logic               frame_end_c;
  logic [3:0]         nib_c;
  logic               pri_dp_c;
  logic [7:0]         alt_byte_c;
  logic               lead_zero_c;

  // Standard active-low {g,f,e,d,c,b,a} patterns; non-decimal nibbles blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Digit scan, ownership state machine and blink phase, all stepped by scan_tick.
  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    hold_cnt_d  = hold_cnt_q;
    cool_cnt_d  = cool_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;

    frame_end_c = scan_tick && (digit_q == DIG_W'(3));

    if (scan_tick) begin
      digit_d = digit_q + DIG_W'(1);
    end

    if (frame_end_c) begin
      case (state_q)
        ST_PRI: begin
          if (alt_req) begin
            state_d    = ST_ALT;
            hold_cnt_d = '0;
          end
        end
        ST_ALT: begin
          if (!alt_req) begin
            state_d = ST_PRI;
          end else if (hold_cnt_q == HOLD_W'(HOLD_FRAMES - 1)) begin
            state_d    = ST_COOL;
            cool_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_COOL: begin
          if (cool_cnt_q == COOL_W'(MIN_PRI_FRAMES - 1)) begin
            state_d = ST_PRI;
          end else begin
            cool_cnt_d = cool_cnt_q + COOL_W'(1);
          end
        end
        default: begin
          state_d = ST_PRI;
        end
      endcase

      // Blink phase runs every frame regardless of owner or blink enable.
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Select the source data for the digit about to be shown.
  always_comb begin
    nib_c       = 4'h0;
    pri_dp_c    = 1'b0;
    alt_byte_c  = 8'hFF;
    lead_zero_c = 1'b0;
    case (digit_d)
      2'd0: begin
        nib_c      = pri_bcd[3:0];
        pri_dp_c   = pri_dp[0];
        alt_byte_c = alt_seg[7:0];
      end
      2'd1: begin
        nib_c      = pri_bcd[7:4];
        pri_dp_c   = pri_dp[1];
        alt_byte_c = alt_seg[15:8];
      end
      2'd2: begin
        nib_c      = pri_bcd[11:8];
        pri_dp_c   = pri_dp[2];
        alt_byte_c = alt_seg[23:16];
      end
      default: begin
        nib_c      = pri_bcd[15:12];
        pri_dp_c   = pri_dp[3];
        alt_byte_c = alt_seg[31:24];
      end
    endcase
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    case (digit_d)
      2'd3:    lead_zero_c = (pri_bcd[15:12] == 4'h0);
      2'd2:    lead_zero_c = (pri_bcd[15:8]  == 8'h00);
      2'd1:    lead_zero_c = (pri_bcd[15:4]  == 12'h000);
      default: lead_zero_c = 1'b0;
    endcase
`else
    lead_zero_c = 1'b0;
`endif
  end

  // Output pixel: loads with the new digit on each scan_tick, otherwise holds.
  always_comb begin
    an_d      = an_q;
    sseg_d    = sseg_q;
    alt_gnt_d = (state_d == ST_ALT);
    if (scan_tick) begin
      an_d = ~(4'b0001 << digit_d);
      if (state_d == ST_ALT) begin
        sseg_d = alt_byte_c;
      end else if (blink && !blink_on_d) begin
        sseg_d = 8'hFF;
      end else if (lead_zero_c) begin
        sseg_d = 8'hFF;
      end else begin
        sseg_d = {~pri_dp_c, bcd_to_seg(nib_c)};
      end
    end
  end

  // State and output registers; reset clears to a dark display owned by primary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PRI;
      digit_q     <= '0;
      hold_cnt_q  <= '0;
      cool_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      alt_gnt_q   <= 1'b0;
      an_q        <= 4'hF;
      sseg_q      <= 8'hFF;
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      hold_cnt_q  <= hold_cnt_d;
      cool_cnt_q  <= cool_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      alt_gnt_q   <= alt_gnt_d;
      an_q        <= an_d;
      sseg_q      <= sseg_d;
    end
  end

  assign alt_gnt = alt_gnt_q;
  assign an      = an_q;
  assign sseg    = sseg_q;

endmodule

// File: tb/tb_sseg_scan_arbiter.sv
// Testbench for sseg_scan_arbiter: directed literal checks plus randomized
// stimulus compared every cycle against a frame-level behavioural model.
module tb_sseg_scan_arbiter;

  localparam int unsigned HOLD  = 3;
  localparam int unsigned MINP  = 2;
  localparam int unsigned BLINK = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scan_tick = 1'b0;
  logic [15:0] pri_bcd = 16'h0000;
  logic [3:0]  pri_dp = 4'h0;
  logic        blink = 1'b0;
  logic        alt_req = 1'b0;
  logic [31:0] alt_seg = 32'hFFFFFFFF;
  logic        alt_gnt;
  logic [3:0]  an;
  logic [7:0]  sseg;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  sseg_scan_arbiter #(
    .HOLD_FRAMES(HOLD),
    .MIN_PRI_FRAMES(MINP),
    .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .scan_tick(scan_tick),
    .pri_bcd(pri_bcd),
    .pri_dp(pri_dp),
    .blink(blink),
    .alt_req(alt_req),
    .alt_seg(alt_seg),
    .alt_gnt(alt_gnt),
    .an(an),
    .sseg(sseg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (n > 4'd9) return 7'h7F;
    return tbl[n];
  endfunction

  // ---------------- behavioural model ----------------
  int   m_digit = 0;     // digit currently shown
  bit   m_alt = 1'b0;    // alternate owns the current frame
  int   m_used = 0;      // frames completed in current grant
  int   m_cool = 0;      // cooldown frames still owed to primary
  int   m_frames = 0;    // frame boundaries since reset
  logic [3:0] exp_an = 4'hF;
  logic [7:0] exp_sseg = 8'hFF;
  logic       exp_gnt = 1'b0;

  always @(posedge clk or posedge reset) begin
    logic [3:0] nib;
    bit lz;
    if (reset) begin
      m_digit = 0; m_alt = 1'b0; m_used = 0; m_cool = 0; m_frames = 0;
      exp_an = 4'hF; exp_sseg = 8'hFF; exp_gnt = 1'b0;
    end else if (scan_tick) begin
      if (m_digit == 3) begin
        m_frames++;
        if (m_alt) begin
          m_used++;
          if (!alt_req) m_alt = 1'b0;
          else if (m_used == HOLD) begin
            m_alt = 1'b0;
            m_cool = MINP;
          end
        end else if (m_cool > 0) begin
          m_cool--;
        end else if (alt_req) begin
          m_alt = 1'b1;
          m_used = 0;
        end
      end
      m_digit = (m_digit + 1) % 4;
      exp_an = 4'hF;
      exp_an[m_digit] = 1'b0;
      exp_gnt = m_alt;
      nib = 4'(pri_bcd >> (4 * m_digit));
      lz = 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      if (m_digit > 0 && 16'(pri_bcd >> (4 * m_digit)) == 16'd0) lz = 1'b1;
`endif
      if (m_alt) exp_sseg = alt_seg[8*m_digit +: 8];
      else if (blink && ((m_frames / BLINK) % 2) == 1) exp_sseg = 8'hFF;
      else if (lz) exp_sseg = 8'hFF;
      else exp_sseg = {~pri_dp[m_digit], seg7(nib)};
    end
  end

  // Compare process: outputs checked on every falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("an", 32'(an), 32'(exp_an));
      chk("sseg", 32'(sseg), 32'(exp_sseg));
      chk("alt_gnt", 32'(alt_gnt), 32'(exp_gnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic tick_every4();
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    step(); step(); step();
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 2) == 0) v[4*i +: 4] = 4'h0;
      else v[4*i +: 4] = 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  initial begin
    logic [7:0] exp_dig [4];
    int mode;

    // Reset state.
    step();
    reset = 1'b1;
    step();
    check_en = 1'b1;
    chk("rst_an", 32'(an), 32'h0000000F);
    chk("rst_sseg", 32'(sseg), 32'h000000FF);
    chk("rst_gnt", 32'(alt_gnt), 32'h0);
    step();
    reset = 1'b0;
    step();

    // Primary 1234 scan; digits 1,2,3,0 in scan order after reset.
    pri_bcd = 16'h1234;
    step();
    exp_dig = '{8'hB0, 8'hA4, 8'hF9, 8'h99};
    for (int k = 0; k < 4; k++) begin
      logic [3:0] ea;
      int d;
      d = (k + 1) % 4;
      ea = 4'hF;
      ea[d] = 1'b0;
      scan_tick = 1'b1;
      step();
      scan_tick = 1'b0;
      chk("dir_an", 32'(an), 32'(ea));
      chk("dir_sseg", 32'(sseg), 32'(exp_dig[k]));
      step(); step(); step();
    end

    // Grant at the next boundary, then reset mid-grant at digit 2.
    alt_seg = 32'h11223344;
    alt_req = 1'b1;
    for (int k = 0; k < 4; k++) tick_every4();
    chk("grant_gnt", 32'(alt_gnt), 32'h1);
    chk("grant_seg0", 32'(sseg), 32'h44);
    tick_every4();
    tick_every4();
    chk("grant_an2", 32'(an), 32'hB);
    chk("grant_seg2", 32'(sseg), 32'h22);
    reset = 1'b1;
    #1;
    chk("async_gnt", 32'(alt_gnt), 32'h0);
    chk("async_an", 32'(an), 32'hF);
    chk("async_sseg", 32'(sseg), 32'hFF);
    step();
    reset = 1'b0;
    alt_req = 1'b0;
    step();
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    chk("restart_an", 32'(an), 32'hD);
    step();

    // Randomized traffic against the model.
    mode = 0;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      if (cyc % 400 == 0) mode = $urandom_range(0, 3);
      case (mode)
        0: scan_tick = ($urandom_range(0, 3) == 0);
        1: scan_tick = 1'b1;
        2: scan_tick = ($urandom_range(0, 1) == 0);
        default: scan_tick = ($urandom_range(0, 7) == 0);
      endcase
      if ($urandom_range(0, (mode == 1) ? 39 : 15) == 0) alt_req = ~alt_req;
      if ($urandom_range(0, 63) == 0) pri_bcd = rand_bcd();
      if ($urandom_range(0, 31) == 0) pri_dp = 4'($urandom);
      if ($urandom_range(0, 149) == 0) blink = ~blink;
      if ($urandom_range(0, 7) == 0) alt_seg = $urandom;
      if ($urandom_range(0, 2999) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      step();
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
